// File: rtl/gsu_pkg.sv
// Shared constants and FSM encoding for the GSU instruction-cache front end.
package gsu_pkg;
  localparam int LINE_BYTES  = 16;
  localparam int NUM_LINES   = 32;
  localparam int CACHE_BYTES = LINE_BYTES * NUM_LINES;
  localparam int MEM_AW      = 24;
  localparam logic [15:0] CACHE_WIN_BASE = 16'h3100;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, FILL_REQ, FILL_WAIT, BYPASS_WAIT, ACK
  } fill_state_e;
endpackage

// File: rtl/gsu_cache_ram.sv
// 512x8 code cache RAM: one write port (fill beats SNES), registered core and SNES read ports.
module gsu_cache_ram #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fill_we,
  input  logic [AW-1:0] fill_addr,
  input  logic [7:0]    fill_data,
  input  logic          snes_we,
  input  logic [AW-1:0] snes_addr,
  input  logic [7:0]    snes_di,
  input  logic [AW-1:0] core_raddr,
  output logic [7:0]    core_rdata,
  output logic [7:0]    snes_rdata
);
  logic [7:0]    mem [DEPTH];
  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;
  logic [7:0]    core_rdata_q, snes_rdata_q;

  // SNES writes only happen while the core is stopped; on a clash the fill data must survive.
  always_comb begin
    we    = fill_we | snes_we;
    waddr = fill_we ? fill_addr : snes_addr;
    wdata = fill_we ? fill_data : snes_di;
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_rdata_q <= '0;
      snes_rdata_q <= '0;
    end else begin
      core_rdata_q <= mem[core_raddr];
      snes_rdata_q <= mem[snes_addr];
    end
  end

  assign core_rdata = core_rdata_q;
  assign snes_rdata = snes_rdata_q;
endmodule

// File: rtl/gsu_cache_fill.sv
// GSU instruction-cache front end: hit/miss lookup, 16-byte line fill, uncached bypass, SNES window.
module gsu_cache_fill #(
  parameter int LINE_BYTES = gsu_pkg::LINE_BYTES,
  parameter int NUM_LINES  = gsu_pkg::NUM_LINES,
  parameter int MEM_AW     = gsu_pkg::MEM_AW
) (
  input  logic                 clkin,
  input  logic                 rst_n,
  input  logic                 fetch_req,
  input  logic [15:0]          fetch_pc,
  input  logic [7:0]           pbr,
  input  logic [15:0]          cbr,
  output logic                 fetch_ack,
  output logic [7:0]           fetch_byte,
  input  logic                 cache_flush,
  input  logic                 snes_we,
  input  logic [8:0]           snes_addr,
  input  logic [7:0]           snes_di,
  output logic [7:0]           snes_do,
  output logic                 mem_rd_req,
  output logic [MEM_AW-1:0]    mem_addr,
  input  logic                 mem_rd_ack,
  input  logic [7:0]           mem_data,
  output logic                 busy,
  output logic [NUM_LINES-1:0] valid_flags
);
  import gsu_pkg::*;

  localparam int CB = NUM_LINES * LINE_BYTES;
  localparam int AW = $clog2(CB);
  localparam int LW = $clog2(LINE_BYTES);
  localparam int NW = AW - LW;

  fill_state_e          state_q, state_d;
  logic [LW-1:0]        fill_cnt_q, fill_cnt_d;
  logic [NW-1:0]        line_q, line_d;
  logic                 abort_q, abort_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic                 fetch_ack_q, fetch_ack_d;
  logic [7:0]           fetch_byte_q, fetch_byte_d;
  logic                 mem_rd_req_q, mem_rd_req_d;
  logic [MEM_AW-1:0]    mem_addr_q, mem_addr_d;

  logic [15:0] off;
  logic        cacheable;
  logic        fill_we;
  logic        fill_done;
  logic [7:0]  core_rdata;

  assign off       = fetch_pc - cbr;
  assign cacheable = off < 16'(CB);
  assign fill_we   = (state_q == FILL_WAIT) && mem_rd_ack;

  always_comb begin
    state_d      = state_q;
    fill_cnt_d   = fill_cnt_q;
    line_d       = line_q;
    abort_d      = abort_q;
    valid_d      = valid_q;
    fetch_ack_d  = 1'b0;
    fetch_byte_d = fetch_byte_q;
    mem_rd_req_d = mem_rd_req_q;
    mem_addr_d   = mem_addr_q;
    fill_done    = 1'b0;

    case (state_q)
      // fetch_req is still high in the ack cycle; don't restart on it
      IDLE: if (fetch_req && !fetch_ack_q) state_d = LOOKUP;
      LOOKUP: begin
        line_d = off[AW-1:LW];
        if (!cacheable) begin
          mem_addr_d   = MEM_AW'({pbr, fetch_pc});
          mem_rd_req_d = 1'b1;
          state_d      = BYPASS_WAIT;
        end else if (valid_q[off[AW-1:LW]]) begin
          state_d = ACK;
        end else begin
          fill_cnt_d = '0;
          abort_d    = 1'b0;
          state_d    = FILL_REQ;
        end
      end
      FILL_REQ: begin
        mem_addr_d   = MEM_AW'({pbr, fetch_pc[15:LW], fill_cnt_q});
        mem_rd_req_d = 1'b1;
        state_d      = FILL_WAIT;
      end
      FILL_WAIT: if (mem_rd_ack) begin
        mem_rd_req_d = 1'b0;
        if (abort_q || cache_flush) begin
          abort_d = 1'b0;
          state_d = LOOKUP;
        end else if (fill_cnt_q == '1) begin
          fill_done = 1'b1;
          state_d   = LOOKUP;
        end else begin
          fill_cnt_d = fill_cnt_q + 1'b1;
          state_d    = FILL_REQ;
        end
      end
      BYPASS_WAIT: if (mem_rd_ack) begin
        mem_rd_req_d = 1'b0;
        fetch_byte_d = mem_data;
        fetch_ack_d  = 1'b1;
        state_d      = IDLE;
      end
      ACK: begin
        fetch_byte_d = core_rdata;
        fetch_ack_d  = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A flush mid-fill lets the in-flight beat land, then restarts the line from byte 0.
    if (cache_flush && (state_q == FILL_REQ || (state_q == FILL_WAIT && !mem_rd_ack)))
      abort_d = 1'b1;

    if (fill_done) valid_d[line_q] = 1'b1;
    if (snes_we && !fill_we && snes_addr[LW-1:0] == '1) valid_d[snes_addr[8:LW]] = 1'b1;
    if (cache_flush) valid_d = '0;
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fill_cnt_q   <= '0;
      line_q       <= '0;
      abort_q      <= 1'b0;
      valid_q      <= '0;
      fetch_ack_q  <= 1'b0;
      fetch_byte_q <= '0;
      mem_rd_req_q <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      fill_cnt_q   <= fill_cnt_d;
      line_q       <= line_d;
      abort_q      <= abort_d;
      valid_q      <= valid_d;
      fetch_ack_q  <= fetch_ack_d;
      fetch_byte_q <= fetch_byte_d;
      mem_rd_req_q <= mem_rd_req_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  gsu_cache_ram #(.DEPTH(CB), .AW(AW)) u_ram (
    .clk        (clkin),
    .rst_n      (rst_n),
    .fill_we    (fill_we),
    .fill_addr  ({line_q, fill_cnt_q}),
    .fill_data  (mem_data),
    .snes_we    (snes_we),
    .snes_addr  (snes_addr),
    .snes_di    (snes_di),
    .core_raddr (off[AW-1:0]),
    .core_rdata (core_rdata),
    .snes_rdata (snes_do)
  );

  assign fetch_ack   = fetch_ack_q;
  assign fetch_byte  = fetch_byte_q;
  assign mem_rd_req  = mem_rd_req_q;
  assign mem_addr    = mem_addr_q;
  assign busy        = (state_q != IDLE);
  assign valid_flags = valid_q;
endmodule

// File: tb/tb_gsu_cache_fill.sv
// Bench for gsu_cache_fill: vector table, corner-case sequences, random ops against a cache model.
module tb_gsu_cache_fill;
  logic        clkin = 0, rst_n = 0;
  logic        fetch_req = 0;
  logic [15:0] fetch_pc = 0, cbr = 0;
  logic [7:0]  pbr = 0;
  logic        fetch_ack;
  logic [7:0]  fetch_byte;
  logic        cache_flush = 0, snes_we = 0;
  logic [8:0]  snes_addr = 0;
  logic [7:0]  snes_di = 0, snes_do;
  logic        mem_rd_req, mem_rd_ack = 0;
  logic [23:0] mem_addr;
  logic [7:0]  mem_data = 0;
  logic        busy;
  logic [31:0] valid_flags;

  gsu_cache_fill dut (
    .clkin(clkin), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_pc(fetch_pc), .pbr(pbr),
    .cbr(cbr), .fetch_ack(fetch_ack), .fetch_byte(fetch_byte), .cache_flush(cache_flush),
    .snes_we(snes_we), .snes_addr(snes_addr), .snes_di(snes_di), .snes_do(snes_do),
    .mem_rd_req(mem_rd_req), .mem_addr(mem_addr), .mem_rd_ack(mem_rd_ack), .mem_data(mem_data),
    .busy(busy), .valid_flags(valid_flags)
  );

  always #5 clkin = ~clkin;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Memory responder: answers every request with its low address byte after a random delay.
  logic [23:0] req_log[$];
  bit          mem_en = 1;
  int          lat_cnt = 0, stab_err = 0;
  logic        prev_req = 0;
  logic [23:0] prev_addr = 0;

  always @(negedge clkin) begin
    if (mem_rd_req && prev_req && mem_addr !== prev_addr) stab_err++;
    prev_req  = mem_rd_req;
    prev_addr = mem_addr;
    if (mem_en) begin
      if (mem_rd_ack) mem_rd_ack = 0;
      else if (mem_rd_req) begin
        if (lat_cnt == 0) begin
          mem_rd_ack = 1;
          mem_data   = mem_addr[7:0];
          req_log.push_back(mem_addr);
          lat_cnt = $urandom_range(0, 2);
        end else lat_cnt--;
      end
    end
  end

  // Reference model: byte array, written-map and line valid bits.
  logic [7:0]  rmem [512];
  bit          rwr  [512];
  logic [31:0] rvalid = 0;

  task automatic model_fetch(input logic [15:0] pc, input logic [15:0] cb, input logic [7:0] pb,
                             output logic [7:0] b, output int nreq, output logic [23:0] first);
    logic [15:0] o;
    int ln;
    o = pc - cb;
    first = 0;
    if (o < 16'd512) begin
      ln = int'(o) / 16;
      nreq = 0;
      if (!rvalid[ln]) begin
        nreq  = 16;
        first = {pb, pc[15:4], 4'h0};
        for (int i = 0; i < 16; i++) begin
          rmem[ln*16+i] = 8'(first + 24'(i));
          rwr[ln*16+i]  = 1;
        end
        rvalid[ln] = 1;
      end
      b = rmem[int'(o)];
    end else begin
      nreq  = 1;
      first = {pb, pc};
      b     = pc[7:0];
    end
  endtask

  task automatic do_fetch(input logic [15:0] pc, output logic [7:0] b, output int lat);
    req_log.delete();
    fetch_pc  = pc;
    fetch_req = 1;
    lat = 0;
    do begin @(negedge clkin); lat++; end while (!fetch_ack && lat < 1000);
    chk("fetch_timeout", int'(pc), {31'd0, fetch_ack}, 32'd1);
    b = fetch_byte;
    fetch_req = 0;
  endtask

  task automatic snes_write(input logic [8:0] a, input logic [7:0] d);
    @(negedge clkin);
    snes_we = 1; snes_addr = a; snes_di = d;
    @(negedge clkin);
    snes_we = 0;
    rmem[a] = d; rwr[a] = 1;
    if (a[3:0] == 4'hF) rvalid[a[8:4]] = 1;
  endtask

  task automatic snes_read_chk(input logic [8:0] a);
    @(negedge clkin); snes_addr = a;
    @(negedge clkin);
    chk("snes_do", int'(a), {24'd0, snes_do}, {24'd0, rmem[a]});
  endtask

  task automatic flush_pulse();
    @(negedge clkin); cache_flush = 1;
    @(negedge clkin); cache_flush = 0;
    rvalid = 0;
  endtask

  typedef struct {
    logic [15:0] cb;
    logic [7:0]  pb;
    logic [15:0] pc;
    logic [7:0]  exp_b;
    int          exp_n;
    logic [23:0] exp_first;
    logic [31:0] exp_valid;
    int          exp_lat;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  b, mb;
    logic [23:0] mf;
    int lat, mn, w;

    vecs[0] = '{16'h0000, 8'h00, 16'h0005, 8'h05, 0,  24'h000000, 32'h1, 3};
    vecs[1] = '{16'h8000, 8'h01, 16'h8023, 8'h23, 16, 24'h018020, 32'h5, 0};
    vecs[2] = '{16'h8000, 8'h01, 16'h8024, 8'h24, 0,  24'h000000, 32'h5, 3};
    vecs[3] = '{16'h8000, 8'h01, 16'h8200, 8'h00, 1,  24'h018200, 32'h5, 0};
    vecs[4] = '{16'h8000, 8'h01, 16'h802F, 8'h2F, 0,  24'h000000, 32'h5, 3};
    vecs[5] = '{16'h8000, 8'h01, 16'h8030, 8'h30, 16, 24'h018030, 32'hD, 0};
    vecs[6] = '{16'h8000, 8'h01, 16'h7FFF, 8'hFF, 1,  24'h017FFF, 32'hD, 0};
    vecs[7] = '{16'hFFF0, 8'h02, 16'h0005, 8'h05, 16, 24'h020000, 32'hF, 0};
    vecs[8] = '{16'hFFF0, 8'h02, 16'hFFF3, 8'h03, 0,  24'h000000, 32'hF, 3};

    // reset state
    #12;
    chk("rst_fetch_ack", 0, {31'd0, fetch_ack}, 0);
    chk("rst_fetch_byte", 0, {24'd0, fetch_byte}, 0);
    chk("rst_snes_do", 0, {24'd0, snes_do}, 0);
    chk("rst_mem_rd_req", 0, {31'd0, mem_rd_req}, 0);
    chk("rst_mem_addr", 0, {8'd0, mem_addr}, 0);
    chk("rst_busy", 0, {31'd0, busy}, 0);
    chk("rst_valid", 0, valid_flags, 0);
    @(negedge clkin); rst_n = 1;

    // SNES preloads line 0, last byte sets the valid flag
    for (int i = 0; i < 16; i++) snes_write(9'(i), 8'(i));
    @(negedge clkin);
    chk("snes_line_valid", 0, valid_flags, 32'h1);
    snes_read_chk(9'd5);

    // vector table
    for (int v = 0; v < 9; v++) begin
      cbr = vecs[v].cb; pbr = vecs[v].pb;
      do_fetch(vecs[v].pc, b, lat);
      model_fetch(vecs[v].pc, vecs[v].cb, vecs[v].pb, mb, mn, mf);
      chk("vec_byte", v, {24'd0, b}, {24'd0, vecs[v].exp_b});
      chk("vec_nreq", v, req_log.size(), vecs[v].exp_n);
      for (int i = 0; i < vecs[v].exp_n && i < req_log.size(); i++)
        chk("vec_addr", v*100+i, {8'd0, req_log[i]}, {8'd0, vecs[v].exp_first + 24'(i)});
      @(negedge clkin);
      chk("vec_valid", v, valid_flags, vecs[v].exp_valid);
      if (vecs[v].exp_lat != 0) chk("vec_hit_lat", v, lat, vecs[v].exp_lat);
    end

    // flush while idle clears flags only
    flush_pulse();
    chk("flush_idle_valid", 0, valid_flags, 0);

    // flush after the 5th fill beat: in-flight beat lands, line refills from byte 0
    cbr = 16'h0000; pbr = 8'h03;
    fork
      do_fetch(16'h0007, b, lat);
      begin
        w = 0;
        while (req_log.size() < 5 && w < 2000) begin @(negedge clkin); #1; w++; end
        chk("flush_mid_wait", 0, req_log.size(), 5);
        @(negedge clkin); cache_flush = 1;
        @(negedge clkin); cache_flush = 0;
        chk("flush_mid_valid", 0, valid_flags, 0);
      end
    join
    rvalid = 0;
    model_fetch(16'h0007, 16'h0000, 8'h03, mb, mn, mf);
    chk("flush_mid_byte", 0, {24'd0, b}, 32'h07);
    chk("flush_mid_nreq", 0, req_log.size(), 22);
    for (int i = 0; i < 6 && i < req_log.size(); i++)
      chk("flush_mid_pre", i, {8'd0, req_log[i]}, {8'd0, 24'h030000 + 24'(i)});
    for (int i = 0; i < 16 && i + 6 < req_log.size(); i++)
      chk("flush_mid_refill", i, {8'd0, req_log[i+6]}, {8'd0, 24'h030000 + 24'(i)});
    @(negedge clkin);
    chk("flush_mid_final_valid", 0, valid_flags, 32'h1);

    // flush and SNES valid-set in the same cycle: flush wins, data still written
    @(negedge clkin);
    snes_we = 1; snes_addr = 9'h01F; snes_di = 8'hC3; cache_flush = 1;
    @(negedge clkin);
    snes_we = 0; cache_flush = 0;
    rmem[9'h01F] = 8'hC3; rwr[9'h01F] = 1; rvalid = 0;
    chk("flush_snes_valid", 0, valid_flags, 0);
    snes_read_chk(9'h01F);

    // rebuild a couple of lines so the reset check has flags to clear
    cbr = 16'h0000; pbr = 8'h00;
    do_fetch(16'h0012, b, lat); model_fetch(16'h0012, 16'h0000, 8'h00, mb, mn, mf);
    chk("pre_rst_byte", 0, {24'd0, b}, {24'd0, mb});

    // reset in the middle of a fill; a late ack must be ignored
    req_log.delete();
    pbr = 8'h04; fetch_pc = 16'h0105; fetch_req = 1;
    w = 0;
    while (req_log.size() < 3 && w < 2000) begin @(negedge clkin); #1; w++; end
    chk("rst_mid_wait", 0, req_log.size(), 3);
    @(posedge clkin); #2;
    rst_n = 0; mem_en = 0; mem_rd_ack = 0; fetch_req = 0;
    #1;
    chk("rst_mid_req", 0, {31'd0, mem_rd_req}, 0);
    chk("rst_mid_busy", 0, {31'd0, busy}, 0);
    chk("rst_mid_valid", 0, valid_flags, 0);
    chk("rst_mid_fbyte", 0, {24'd0, fetch_byte}, 0);
    @(negedge clkin); rst_n = 1;
    @(negedge clkin); mem_rd_ack = 1; mem_data = 8'h5A;
    @(negedge clkin); mem_rd_ack = 0;
    chk("late_ack_busy", 0, {31'd0, busy}, 0);
    chk("late_ack_req", 0, {31'd0, mem_rd_req}, 0);
    chk("late_ack_fack", 0, {31'd0, fetch_ack}, 0);
    chk("late_ack_valid", 0, valid_flags, 0);
    mem_en = 1; lat_cnt = 0;
    rvalid = 0;
    for (int i = 0; i < 16; i++) rwr[16*16+i] = 0;

    // random operations against the model
    for (int op = 0; op < 150; op++) begin
      int k;
      k = $urandom_range(0, 99);
      if (k < 60) begin
        int r;
        r = $urandom_range(0, 3);
        cbr = (r == 0) ? 16'h0000 : (r == 1) ? 16'h8000 : (r == 2) ? 16'hFFF0 : 16'h1230;
        pbr = 8'($urandom_range(0, 3));
        fetch_pc = cbr + 16'($urandom_range(0, 700));
        do_fetch(fetch_pc, b, lat);
        model_fetch(fetch_pc, cbr, pbr, mb, mn, mf);
        chk("rnd_byte", op, {24'd0, b}, {24'd0, mb});
        chk("rnd_nreq", op, req_log.size(), mn);
        if (mn > 0 && req_log.size() > 0)
          chk("rnd_first", op, {8'd0, req_log[0]}, {8'd0, mf});
        if (mn == 16 && req_log.size() == 16)
          chk("rnd_last", op, {8'd0, req_log[15]}, {8'd0, mf + 24'd15});
        if (mn == 0) chk("rnd_hit_lat", op, lat, 3);
        @(negedge clkin);
        chk("rnd_valid", op, valid_flags, rvalid);
      end else if (k < 75) begin
        int a;
        a = $urandom_range(0, 31) * 16 + $urandom_range(0, 14);
        snes_write(9'(a), 8'($urandom));
        chk("rnd_sw_valid", op, valid_flags, rvalid);
      end else if (k < 80) begin
        int ln;
        ln = $urandom_range(0, 31);
        for (int i = 0; i < 16; i++) snes_write(9'(ln*16 + i), 8'($urandom));
        chk("rnd_line_valid", op, valid_flags, rvalid);
      end else if (k < 90) begin
        int a;
        a = $urandom_range(0, 511);
        if (rwr[a]) snes_read_chk(9'(a));
      end else begin
        flush_pulse();
        chk("rnd_flush_valid", op, valid_flags, 0);
      end
    end

    chk("mem_addr_stable", 0, stab_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
